// File: rtl/alu_rr_scheduler_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes, FSM encoding
// and the ALU result bundle.
package alu_pkg;

    localparam int DW = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef struct packed {
        logic [DW-1:0] result;
        logic          carry;
        logic          zero;
        logic          err;
    } alu_out_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the requester front-ends and the shared
// ALU scheduler.
interface alu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_a;
    logic [NUM_REQ*DW-1:0] req_b;
    logic [NUM_REQ*3-1:0]  req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [DW-1:0]         rsp_result;
    logic                  rsp_carry;
    logic                  rsp_zero;
    logic                  rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_rr_scheduler_alu_core.sv
// Combinational 4-bit ALU; carry/borrow taken from a one-bit-wider intermediate,
// illegal opcodes flag err and force the result to zero.
module alu_core
    import alu_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    op,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero,
    output logic          err
);

    logic [DW:0] sum_s;
    logic [DW:0] diff_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};

    // Opcode decode and flag generation
    always_comb begin
        result = {DW{1'b0}};
        carry  = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum_s[DW-1:0];
                carry  = sum_s[DW];
            end
            OP_SUB: begin
                result = diff_s[DW-1:0];
                carry  = diff_s[DW];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: err = 1'b1;
        endcase
        zero = (result == {DW{1'b0}});
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU between NUM_REQ requesters; one request
// in flight, IDLE -> EXEC -> RESP, pointer advances on response completion.
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_rr_scheduler_if.slave bus
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [1:0]         state_r;
    logic [IDW-1:0]     ptr_r;
    logic [IDW-1:0]     id_r;
    logic [DW-1:0]      a_r;
    logic [DW-1:0]      b_r;
    logic [2:0]         op_r;
    logic               rsp_valid_r;
    logic [IDW-1:0]     rsp_id_r;
    alu_out_t           rsp_r;

    logic               grant_found_s;
    logic [IDW-1:0]     grant_id_s;
    logic [NUM_REQ-1:0] ready_s;
    logic [DW-1:0]      a_sel_s;
    logic [DW-1:0]      b_sel_s;
    logic [2:0]         op_sel_s;
    logic [IDW-1:0]     ptr_next_s;
    alu_out_t           alu_s;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s;
        end
        return IDW'(s);
    endfunction

    // First valid requester at or above ptr, wrapping
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = {IDW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found_s && bus.req_valid[rr_idx(ptr_r, k)]) begin
                grant_found_s = 1'b1;
                grant_id_s    = rr_idx(ptr_r, k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Grant strobe and operand mux for the winning requester
    always_comb begin
        a_sel_s  = {DW{1'b0}};
        b_sel_s  = {DW{1'b0}};
        op_sel_s = 3'b000;
        for (int k = 0; k < NUM_REQ; k++) begin
            ready_s[k] = (state_r == IDLE) && grant_found_s && (grant_id_s == IDW'(k));
            if (grant_id_s == IDW'(k)) begin
                a_sel_s  = bus.req_a[k*DW +: DW];
                b_sel_s  = bus.req_b[k*DW +: DW];
                op_sel_s = bus.req_op[k*3 +: 3];
            end else begin
                a_sel_s  = a_sel_s;
            end
        end
    end

    assign ptr_next_s = (id_r == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : (id_r + IDW'(1));

    alu_core u_alu (
        .a      (a_r),
        .b      (b_r),
        .op     (op_r),
        .result (alu_s.result),
        .carry  (alu_s.carry),
        .zero   (alu_s.zero),
        .err    (alu_s.err)
    );

    // Control FSM, arbitration pointer and operand latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= {IDW{1'b0}};
            id_r    <= {IDW{1'b0}};
            a_r     <= {DW{1'b0}};
            b_r     <= {DW{1'b0}};
            op_r    <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        id_r    <= grant_id_s;
                        a_r     <= a_sel_s;
                        b_r     <= b_sel_s;
                        op_r    <= op_sel_s;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: state_r <= RESP;
                RESP: begin
                    if (bus.rsp_ready) begin
                        ptr_r   <= ptr_next_s;
                        state_r <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Response registers: loaded at end of EXEC, held until the consumer takes them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {IDW{1'b0}};
            rsp_r       <= '{result: {DW{1'b0}}, carry: 1'b0, zero: 1'b0, err: 1'b0};
        end else if (state_r == EXEC) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_r;
            rsp_r       <= alu_s;
        end else if ((state_r == RESP) && bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_r.result;
    assign bus.rsp_carry  = rsp_r.carry;
    assign bus.rsp_zero   = rsp_r.zero;
    assign bus.rsp_err    = rsp_r.err;

endmodule
